// File: rtl/regfile_pkg.sv
// Shared definitions for the register file controller.
// State encoding, default geometry and read-latency limit.
package regfile_pkg;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_IDLE = 3'd1,
        ST_WR   = 3'd2,
        ST_RD   = 3'd3,
        ST_RSP  = 3'd4
    } state_t;

    localparam int AW_DEF     = 2;
    localparam int DW_DEF     = 4;
    localparam int RD_LAT_MAX = 3;
    localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/regfile_ctrl_stats.sv
// Saturating write / read-response counters for regfile_ctrl.
// Ports: i_clk, i_rst_n, i_wr_pulse, i_rd_pulse, o_wr_cnt, o_rd_cnt.
module regfile_ctrl_stats (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_pulse,
    input  logic        i_rd_pulse,
    output logic [15:0] o_wr_cnt,
    output logic [15:0] o_rd_cnt
);

    logic [15:0] r_wr_cnt;
    logic [15:0] r_rd_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_cnt <= 16'd0;
            r_rd_cnt <= 16'd0;
        end else begin
            if (i_wr_pulse && (r_wr_cnt != 16'hFFFF))
                r_wr_cnt <= r_wr_cnt + 16'd1;
            if (i_rd_pulse && (r_rd_cnt != 16'hFFFF))
                r_rd_cnt <= r_rd_cnt + 16'd1;
        end
    end

    assign o_wr_cnt = r_wr_cnt;
    assign o_rd_cnt = r_rd_cnt;

endmodule

// File: rtl/regfile_ctrl.sv
// Command-driven initiator for a single-port register file.
// Ports: CLK, RSTn; CMD_VALID/READY/WR/ADDR/DATA command channel;
// RSP_VALID/READY/ADDR/DATA response channel; RF_ADDR/WE/DIN/DOUT
// register file pins. Macro REGFILE_CTRL_STATS_EN adds WR_CNT/RD_CNT.
module regfile_ctrl
    import regfile_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic          CMD_WR,
    input  logic [AW-1:0] CMD_ADDR,
    input  logic [DW-1:0] CMD_DATA,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic [AW-1:0] RSP_ADDR,
    output logic [DW-1:0] RSP_DATA,
    output logic [AW-1:0] RF_ADDR,
    output logic          RF_WE,
    output logic [DW-1:0] RF_DIN,
    input  logic [DW-1:0] RF_DOUT
`ifdef REGFILE_CTRL_STATS_EN
   ,output logic [15:0]   WR_CNT,
    output logic [15:0]   RD_CNT
`endif
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LAT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_rf_addr;
    logic [DW-1:0]    r_rf_din;
    logic             r_rf_we;
    logic             r_rsp_valid;
    logic [AW-1:0]    r_rsp_addr;
    logic [DW-1:0]    r_rsp_data;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= ST_RST;
            r_cnt       <= '0;
            r_rf_addr   <= '0;
            r_rf_din    <= '0;
            r_rf_we     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
        end else begin
            unique case (r_state)
                ST_RST: r_state <= ST_IDLE;
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        r_rf_addr <= CMD_ADDR;
                        r_rf_din  <= CMD_DATA;
                        if (CMD_WR) begin
                            r_rf_we <= 1'b1;
                            r_state <= ST_WR;
                        end else begin
                            r_cnt   <= LAT;
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    r_rf_we <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_RD: begin
                    // counter reaching zero marks RF_DOUT as valid
                    if (r_cnt == '0) begin
                        r_rsp_data  <= RF_DOUT;
                        r_rsp_addr  <= r_rf_addr;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RSP: begin
                    if (RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_RST;
            endcase
        end
    end

    assign CMD_READY = (r_state == ST_IDLE);
    assign RSP_VALID = r_rsp_valid;
    assign RSP_ADDR  = r_rsp_addr;
    assign RSP_DATA  = r_rsp_data;
    assign RF_ADDR   = r_rf_addr;
    assign RF_WE     = r_rf_we;
    assign RF_DIN    = r_rf_din;

`ifdef REGFILE_CTRL_STATS_EN
    logic w_wr_pulse;
    logic w_rd_pulse;

    assign w_wr_pulse = (r_state == ST_WR);
    assign w_rd_pulse = (r_state == ST_RSP) && RSP_READY;

    regfile_ctrl_stats u_stats (
        .i_clk      (CLK),
        .i_rst_n    (RSTn),
        .i_wr_pulse (w_wr_pulse),
        .i_rd_pulse (w_rd_pulse),
        .o_wr_cnt   (WR_CNT),
        .o_rd_cnt   (RD_CNT)
    );
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with behavioural register files.
// Instance u_dut uses RD_LAT=1, u_dut0 uses RD_LAT=0.
module tb_regfile_ctrl;

    logic       clk;
    logic       rstn;

    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [1:0] cmd_addr;
    logic [3:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [1:0] rsp_addr;
    logic [3:0] rsp_data;
    logic [1:0] rf_addr;
    logic       rf_we;
    logic [3:0] rf_din, rf_dout;

    logic       c0_valid, c0_ready, c0_wr;
    logic [1:0] c0_addr;
    logic [3:0] c0_data;
    logic       r0_valid, r0_ready;
    logic [1:0] r0_addr;
    logic [3:0] r0_data;
    logic [1:0] rf0_addr;
    logic       rf0_we;
    logic [3:0] rf0_din, rf0_dout;

`ifdef REGFILE_CTRL_STATS_EN
    logic [15:0] wr_cnt, rd_cnt, wr_cnt0, rd_cnt0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] mem1 [4];
    logic [3:0] mem0 [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one-cycle-latency register file
    always @(posedge clk) begin
        if (rf_we) mem1[rf_addr] <= rf_din;
        rf_dout <= mem1[rf_addr];
    end

    // combinational-read register file
    always @(posedge clk) begin
        if (rf0_we) mem0[rf0_addr] <= rf0_din;
    end
    assign rf0_dout = mem0[rf0_addr];

    regfile_ctrl #(.AW(2), .DW(4), .RD_LAT(1)) u_dut (
        .CLK       (clk),
        .RSTn      (rstn),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_WR    (cmd_wr),
        .CMD_ADDR  (cmd_addr),
        .CMD_DATA  (cmd_data),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .RSP_ADDR  (rsp_addr),
        .RSP_DATA  (rsp_data),
        .RF_ADDR   (rf_addr),
        .RF_WE     (rf_we),
        .RF_DIN    (rf_din),
        .RF_DOUT   (rf_dout)
`ifdef REGFILE_CTRL_STATS_EN
       ,.WR_CNT    (wr_cnt),
        .RD_CNT    (rd_cnt)
`endif
    );

    regfile_ctrl #(.AW(2), .DW(4), .RD_LAT(0)) u_dut0 (
        .CLK       (clk),
        .RSTn      (rstn),
        .CMD_VALID (c0_valid),
        .CMD_READY (c0_ready),
        .CMD_WR    (c0_wr),
        .CMD_ADDR  (c0_addr),
        .CMD_DATA  (c0_data),
        .RSP_VALID (r0_valid),
        .RSP_READY (r0_ready),
        .RSP_ADDR  (r0_addr),
        .RSP_DATA  (r0_data),
        .RF_ADDR   (rf0_addr),
        .RF_WE     (rf0_we),
        .RF_DIN    (rf0_din),
        .RF_DOUT   (rf0_dout)
`ifdef REGFILE_CTRL_STATS_EN
       ,.WR_CNT    (wr_cnt0),
        .RD_CNT    (rd_cnt0)
`endif
    );

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // read on u_dut with RSP_READY high; caller leaves the FSM in IDLE
    task automatic read_chk(input logic [1:0] a, input logic [3:0] d);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = a;
        rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("rd_rf_addr", 16'(rf_addr), 16'(a));
        chk("rd_busy", 16'(cmd_ready), 16'd0);
        chk("rd_nvld1", 16'(rsp_valid), 16'd0);
        step();
        chk("rd_nvld2", 16'(rsp_valid), 16'd0);
        step();
        chk("rd_vld", 16'(rsp_valid), 16'd1);
        chk("rd_addr", 16'(rsp_addr), 16'(a));
        chk("rd_data", 16'(rsp_data), 16'(d));
        step();
        chk("rd_done", 16'(rsp_valid), 16'd0);
        chk("rd_ready", 16'(cmd_ready), 16'd1);
    endtask

    initial begin
        rstn      = 1'b0;
        cmd_valid = 1'b0; cmd_wr = 1'b0;
        cmd_addr  = '0;   cmd_data = '0;
        rsp_ready = 1'b0;
        c0_valid  = 1'b0; c0_wr = 1'b0;
        c0_addr   = '0;   c0_data = '0;
        r0_ready  = 1'b0;

        // reset held 100 ns
        #100;
        chk("rst_ready", 16'(cmd_ready), 16'd0);
        chk("rst_rvld", 16'(rsp_valid), 16'd0);
        chk("rst_raddr", 16'(rsp_addr), 16'd0);
        chk("rst_rdata", 16'(rsp_data), 16'd0);
        chk("rst_rfaddr", 16'(rf_addr), 16'd0);
        chk("rst_we", 16'(rf_we), 16'd0);
        chk("rst_din", 16'(rf_din), 16'd0);
        rstn = 1'b1;
        #1;
        chk("rel_ready0", 16'(cmd_ready), 16'd0);
        step();
        chk("rel_ready1", 16'(cmd_ready), 16'd1);
        chk("rel_ready1_0", 16'(c0_ready), 16'd1);

        // three back-to-back writes, valid held high
        cmd_valid = 1'b1; cmd_wr = 1'b1;
        cmd_addr  = 2'd0; cmd_data = 4'd1;
        step();
        chk("w0_we", 16'(rf_we), 16'd1);
        chk("w0_addr", 16'(rf_addr), 16'd0);
        chk("w0_din", 16'(rf_din), 16'd1);
        chk("w0_busy", 16'(cmd_ready), 16'd0);
        cmd_addr = 2'd1; cmd_data = 4'd2;
        step();
        chk("w0_we_off", 16'(rf_we), 16'd0);
        chk("w0_idle", 16'(cmd_ready), 16'd1);
        step();
        chk("w1_we", 16'(rf_we), 16'd1);
        chk("w1_addr", 16'(rf_addr), 16'd1);
        chk("w1_din", 16'(rf_din), 16'd2);
        cmd_addr = 2'd2; cmd_data = 4'd3;
        step();
        chk("w1_we_off", 16'(rf_we), 16'd0);
        step();
        chk("w2_we", 16'(rf_we), 16'd1);
        chk("w2_addr", 16'(rf_addr), 16'd2);
        chk("w2_din", 16'(rf_din), 16'd3);
        cmd_valid = 1'b0;
        step();
        chk("w2_we_off", 16'(rf_we), 16'd0);
        chk("w2_idle", 16'(cmd_ready), 16'd1);
        chk("w_hold_addr", 16'(rf_addr), 16'd2);

        // reads with RD_LAT=1
        read_chk(2'd0, 4'd1);
        read_chk(2'd1, 4'd2);
        read_chk(2'd2, 4'd3);

        // backpressure on a read of address 1
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 2'd1;
        rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("bp_vld", 16'(rsp_valid), 16'd1);
        chk("bp_data", 16'(rsp_data), 16'd2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_vld", 16'(rsp_valid), 16'd1);
            chk("bp_hold_data", 16'(rsp_data), 16'd2);
            chk("bp_hold_addr", 16'(rsp_addr), 16'd1);
            chk("bp_hold_busy", 16'(cmd_ready), 16'd0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_rel_vld", 16'(rsp_valid), 16'd0);
        chk("bp_rel_ready", 16'(cmd_ready), 16'd1);
        chk("bp_keep_data", 16'(rsp_data), 16'd2);

`ifdef REGFILE_CTRL_STATS_EN
        chk("st_wr", wr_cnt, 16'd3);
        chk("st_rd", rd_cnt, 16'd4);
`endif

        // write then immediate read of address 3, RD_LAT=0
        c0_valid = 1'b1; c0_wr = 1'b1;
        c0_addr  = 2'd3; c0_data = 4'hF;
        step();
        chk("z_we", 16'(rf0_we), 16'd1);
        chk("z_addr", 16'(rf0_addr), 16'd3);
        chk("z_din", 16'(rf0_din), 16'hF);
        c0_wr = 1'b0;
        step();
        chk("z_we_off", 16'(rf0_we), 16'd0);
        chk("z_idle", 16'(c0_ready), 16'd1);
        r0_ready = 1'b1;
        step();
        c0_valid = 1'b0;
        chk("z_nvld", 16'(r0_valid), 16'd0);
        step();
        chk("z_vld", 16'(r0_valid), 16'd1);
        chk("z_data", 16'(r0_data), 16'hF);
        chk("z_raddr", 16'(r0_addr), 16'd3);
        step();
        chk("z_done", 16'(r0_valid), 16'd0);
        chk("z_ready", 16'(c0_ready), 16'd1);

        // reset while waiting in RD
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 2'd2;
        step();
        cmd_valid = 1'b0;
        chk("mr_busy", 16'(cmd_ready), 16'd0);
        rstn = 1'b0;
        #1;
        chk("mr_vld", 16'(rsp_valid), 16'd0);
        chk("mr_rfaddr", 16'(rf_addr), 16'd0);
        chk("mr_ready", 16'(cmd_ready), 16'd0);
        chk("mr_rdata", 16'(rsp_data), 16'd0);
        step();
        chk("mr_vld2", 16'(rsp_valid), 16'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("mr_idle", 16'(cmd_ready), 16'd1);
        chk("mr_vld3", 16'(rsp_valid), 16'd0);
        step();
        chk("mr_vld4", 16'(rsp_valid), 16'd0);
`ifdef REGFILE_CTRL_STATS_EN
        chk("mr_st_wr", wr_cnt, 16'd0);
        chk("mr_st_rd", rd_cnt, 16'd0);
`endif
        // register contents survive controller reset
        read_chk(2'd2, 4'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Command-driven initiator for the single-port register file. Accepts write/read commands over a valid/ready interface and sequences the register file's address, write-enable and data pins. Returns read data over a valid/ready response interface, so a bus or CPU front-end can own the register file without hand-timing its pins.

## Interface
- `AW`, default 2: address width; register file depth is 2**AW.
- `DW`, default 4: data width.
- `RD_LAT`, default 1: cycles from address presented to `RF_DOUT` valid. Legal range 0..3; 0 means combinational read.

Ports:
- `CLK`  in  1  Single clock; all logic on the rising edge.
- `RSTn`  in  1  Asynchronous active-low reset.
- `CMD_VALID`  in  1  Command present.
- `CMD_READY`  out  1  Controller accepts a command this cycle.
- `CMD_WR`  in  1  1 = write, 0 = read.
- `CMD_ADDR`  in  AW  Target register.
- `CMD_DATA`  in  DW  Write data; ignored for reads.
- `RSP_VALID`  out  1  Read response present.
- `RSP_READY`  in  1  Consumer takes the response.
- `RSP_ADDR`  out  AW  Address of the returned read.
- `RSP_DATA`  out  DW  Read data.
- `RF_ADDR`  out  AW  Register file address.
- `RF_WE`  out  1  Register file write enable.
- `RF_DIN`  out  DW  Register file write data.
- `RF_DOUT`  in  DW  Register file read data.

## Operation
- FSM states: `RST`, `IDLE`, `WR`, `RD`, `RSP`.
- **Reset (`RSTn` low, asynchronous):**
  - state = `RST`.
  - All outputs are 0, including `CMD_READY`.
  - Wait counter cleared.
- **`RST`:** goes to `IDLE` on the first rising edge with `RSTn` high.
- **`IDLE`:**
  - `CMD_READY` = 1, combinationally from the state.
  - A command is accepted on an edge where `CMD_VALID && CMD_READY`.
  - On accept, `CMD_ADDR` is latched into `RF_ADDR` and `CMD_DATA` into `RF_DIN`.
  - Next state is `WR` if `CMD_WR`, else `RD`.
- **`WR`:**
  - `RF_WE` = 1 for exactly one cycle, with `RF_ADDR`/`RF_DIN` stable.
  - Returns to `IDLE`.
  - Writes produce no response.
- **`RD`:**
  - `RF_WE` = 0 and `RF_ADDR` held stable.
  - The wait counter loads `RD_LAT` on entry and decrements each cycle.
  - When the counter is 0, `RF_DOUT` is sampled into `RSP_DATA`, `RF_ADDR` is copied into `RSP_ADDR`, and the FSM moves to `RSP`.
- **`RSP`:**
  - `RSP_VALID` = 1.
  - `RSP_DATA`/`RSP_ADDR` hold stable until `RSP_READY` is sampled high.
  - Then `RSP_VALID` drops and the FSM returns to `IDLE`.
- Only one command is in flight; `CMD_READY` = 0 in every state except `IDLE`.
- `RF_ADDR`/`RF_DIN` hold their last values while `IDLE`.
- `RSP_DATA`/`RSP_ADDR` hold after handshake; they are not cleared.
- Addresses are used modulo 2**AW; there is no range check.
- Reset mid-operation aborts immediately:
  - `RF_WE` drops asynchronously and no partial response is issued.
  - Any write not yet reached `WR` is lost.

## Timing
- Write accepted at edge N:
  - `RF_WE` is high from N to N+1.
  - `CMD_READY` is high again after edge N+1.
  - Throughput: one write per 2 cycles.
- Read accepted at edge N:
  - `RF_ADDR` is valid from N.
  - Data is sampled at edge N+1+`RD_LAT`.
  - `RSP_VALID` rises at that same edge.
- With `RSP_READY` held high, `CMD_READY` returns at edge N+2+`RD_LAT`.
- Back-to-back write-then-read to the same address returns the newly written value.

## Configuration
- `REGFILE_CTRL_STATS_EN`:
  - **Defined:** adds 16-bit output ports `WR_CNT` and `RD_CNT`.
    - Each counter increments once per `WR` cycle and once per completed response handshake, respectively.
    - Counters saturate at 16'hFFFF and reset to 0.
  - **Undefined:** the ports and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `regfile_pkg` holds:
  - state encoding constants (`ST_RST`, `ST_IDLE`, `ST_WR`, `ST_RD`, `ST_RSP`, 3-bit);
  - default `AW`/`DW`;
  - the `RD_LAT` maximum.
- Optional sub-module `regfile_ctrl_stats` contains the saturating counters and is instantiated only under `REGFILE_CTRL_STATS_EN`.
- Bench pairs this block with the existing `regfile` instance.

## Test plan
- **Reset:** hold `RSTn` low 100 ns.
  - All outputs are 0.
  - `CMD_READY` rises one edge after release.
- **Writes:** write (0,1), (1,2), (2,3) back-to-back with `CMD_VALID` held high.
  - `RF_WE` shows three single-cycle pulses, two cycles apart.
  - `RF_ADDR`/`RF_DIN` carry 0/1, 1/2, 2/3.
- **Reads:** read addresses 0, 1, 2 with `RD_LAT`=1 and `RSP_READY`=1.
  - Responses are (0,1), (1,2), (2,3).
  - Each `RSP_VALID` rises 2 edges after accept.
- **Backpressure:** read address 1 with `RSP_READY`=0 for 5 cycles.
  - `RSP_VALID`/`RSP_DATA`=2 hold stable.
  - `CMD_READY` stays 0.
  - After release, `CMD_READY` returns the next cycle.
- **Address wrap:** write (3,4'hF), then read address 3 with `RD_LAT`=0.
  - Response is 4'hF, one edge after accept.
- **Reset mid-read:** drop `RSTn` while in `RD`.
  - `RSP_VALID` never asserts.
  - FSM resumes in `IDLE`.
  - With `REGFILE_CTRL_STATS_EN` defined, `WR_CNT`=0 and `RD_CNT`=0.
